// File: rtl/img_frame_packer.sv
// Packs a fixed-size image frame plus a one-line trailer (parity, channel info, padding) into the DDR write FIFO.
// Optional feature: define IMG_FRAME_PACKER_PARITY_EN to accumulate the beat XOR into trailer word 0.
module img_frame_packer #(
  parameter int  DATA_W     = 32,
  parameter int  PIX_SIZE   = 8,
  parameter int  LINE_SIZE  = 1024,
  parameter int  IMAGE_SIZE = 1048576,
  parameter int  NUM_CH     = 4,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              frame_start,
  input  logic [CH_W-1:0]   frame_ch,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [DATA_W-1:0] fifo_wrdata,
  output logic              fifo_wren,
  input  logic              fifo_full,
  output logic              frame_done,
  output logic              frame_stored,
  output logic [CH_W-1:0]   frame_ch_o,
  output logic              sof_err
);

  localparam int LINE_NUM = LINE_SIZE * PIX_SIZE / DATA_W;
  localparam int WR_NUM   = IMAGE_SIZE * PIX_SIZE / DATA_W;
  localparam int BEAT_W   = $clog2(WR_NUM + 1);
  localparam int TW_W     = $clog2(LINE_NUM);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_PARITY, S_INFO, S_PAD, S_DONE} state_e;

  state_e                       state_q, state_d;
  logic [BEAT_W-1:0]            beat_cnt_q, beat_cnt_d;
  logic [TW_W-1:0]              tw_cnt_q, tw_cnt_d;
  logic                         store_q, store_d;
  logic [CH_W-1:0]              frame_ch_q, frame_ch_d;
  logic [NUM_CH-1:0][31:0]      frame_cnt_q, frame_cnt_d;
  logic [DATA_W-1:0]            wrdata_q, wrdata_d;
  logic                         wren_q, wren_d;
  logic                         done_q, done_d;
  logic                         stored_q, stored_d;
  logic                         sof_err_q, sof_err_d;
  logic [DATA_W-1:0]            parity_word;
  logic [DATA_W-1:0]            trailer_word;
  logic                         accept;

`ifdef IMG_FRAME_PACKER_PARITY_EN
  logic [DATA_W-1:0] parity_q, parity_d;
  assign parity_word = parity_q;
`else
  assign parity_word = '0;
`endif

  assign s_ready = (state_q == S_DATA) && !fifo_full;
  assign accept  = s_valid && s_ready;

  // Trailer word selected by the word index; unlisted words are zero padding.
  always_comb begin
    trailer_word = '0;
    if (tw_cnt_q == TW_W'(0))      trailer_word = parity_word;
    else if (tw_cnt_q == TW_W'(4)) trailer_word = DATA_W'({16'd0, 8'(frame_ch_q), 8'd0});
    else if (tw_cnt_q == TW_W'(7)) trailer_word = DATA_W'(frame_cnt_q[frame_ch_q]);
  end

  // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    tw_cnt_d    = tw_cnt_q;
    store_d     = store_q;
    frame_ch_d  = frame_ch_q;
    frame_cnt_d = frame_cnt_q;
    wrdata_d    = wrdata_q;
    wren_d      = 1'b0;
    done_d      = 1'b0;
    stored_d    = 1'b0;
    sof_err_d   = sof_err_q | (frame_start && (state_q != S_IDLE));
`ifdef IMG_FRAME_PACKER_PARITY_EN
    parity_d    = parity_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          frame_ch_d = frame_ch;
          store_d    = ch_en[frame_ch];
          beat_cnt_d = '0;
          tw_cnt_d   = '0;
`ifdef IMG_FRAME_PACKER_PARITY_EN
          parity_d   = '0;
`endif
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          wren_d   = store_q;
          wrdata_d = s_data;
`ifdef IMG_FRAME_PACKER_PARITY_EN
          parity_d = parity_q ^ s_data;
`endif
          if (beat_cnt_q == BEAT_W'(WR_NUM - 1)) begin
            beat_cnt_d = '0;
            state_d    = S_PARITY;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY, S_INFO, S_PAD: begin
        // A trailer word is only issued when the FIFO has room; otherwise the index holds.
        if (!fifo_full) begin
          wren_d   = store_q;
          wrdata_d = trailer_word;
          if (tw_cnt_q == TW_W'(LINE_NUM - 1)) begin
            tw_cnt_d = '0;
            state_d  = S_DONE;
          end else begin
            tw_cnt_d = tw_cnt_q + 1'b1;
            state_d  = (tw_cnt_q < TW_W'(7)) ? S_INFO : S_PAD;
          end
        end
      end
      S_DONE: begin
        done_d   = 1'b1;
        stored_d = store_q;
        if (store_q) frame_cnt_d[frame_ch_q] = frame_cnt_q[frame_ch_q] + 32'd1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      beat_cnt_q  <= '0;
      tw_cnt_q    <= '0;
      store_q     <= 1'b0;
      frame_ch_q  <= '0;
      // NOTE: the per-channel counters are architectural state, so the whole array is reset, not left undefined.
      frame_cnt_q <= '0;
      wrdata_q    <= '0;
      wren_q      <= 1'b0;
      done_q      <= 1'b0;
      stored_q    <= 1'b0;
      sof_err_q   <= 1'b0;
`ifdef IMG_FRAME_PACKER_PARITY_EN
      parity_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      tw_cnt_q    <= tw_cnt_d;
      store_q     <= store_d;
      frame_ch_q  <= frame_ch_d;
      frame_cnt_q <= frame_cnt_d;
      wrdata_q    <= wrdata_d;
      wren_q      <= wren_d;
      done_q      <= done_d;
      stored_q    <= stored_d;
      sof_err_q   <= sof_err_d;
`ifdef IMG_FRAME_PACKER_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign fifo_wrdata  = wrdata_q;
  assign fifo_wren    = wren_q;
  assign frame_done   = done_q;
  assign frame_stored = stored_q;
  assign frame_ch_o   = frame_ch_q;
  assign sof_err      = sof_err_q;

endmodule
